// File: rtl/sprite_blitter.sv
// sprite_blitter: walks a sprite ROM pixel by pixel and emits frame-buffer writes,
// skipping the key colour and off-screen pixels, with optional horizontal mirroring.
// Ports: clk_i/rst_i (async active-high), start_i/pos_x_i/pos_y_i/flip_h_i request,
//   rom_addr_o/rom_color_i ROM side, fb_we_o/fb_ready_i/fb_x_o/fb_y_o/fb_data_o
//   frame-buffer side, busy_o/done_o status.
module sprite_blitter #(
  parameter int          SPRITE_W  = 21,
  parameter int          SPRITE_H  = 41,
  parameter int          SCREEN_W  = 640,
  parameter int          SCREEN_H  = 480,
  parameter logic [11:0] KEY_COLOR = 12'h808
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [9:0]  pos_x_i,
  input  logic [8:0]  pos_y_i,
  input  logic        flip_h_i,
  output logic [9:0]  rom_addr_o,
  input  logic [11:0] rom_color_i,
  output logic        fb_we_o,
  input  logic        fb_ready_i,
  output logic [9:0]  fb_x_o,
  output logic [8:0]  fb_y_o,
  output logic [11:0] fb_data_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(SPRITE_H - 1);
  localparam logic [10:0]   SCR_W    = 11'(SCREEN_W);
  localparam logic [9:0]    SCR_H    = 10'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [9:0]    addr_q, addr_d;
  logic [9:0]    pos_x_q, pos_x_d;
  logic [8:0]    pos_y_q, pos_y_d;
  logic          flip_q, flip_d;

  // Screen coordinates carry one extra bit so a sprite hanging past the right
  // or bottom edge is detected instead of wrapping back onto the screen.
  logic [CW-1:0] col_off;
  logic [10:0]   sx;
  logic [9:0]    sy;
  logic          skip;
  logic          advance;
  logic          last_px;

  assign col_off = flip_q ? (LAST_COL - col_q) : col_q;
  assign sx      = {1'b0, pos_x_q} + 11'(col_off);
  assign sy      = {1'b0, pos_y_q} + 10'(row_q);
  assign skip    = (rom_color_i == KEY_COLOR) || (sx >= SCR_W) || (sy >= SCR_H);
  // Skipped pixels cost one cycle; real writes wait for the frame buffer.
  assign advance = (state_q == DRAW) && (skip || fb_ready_i);
  assign last_px = (col_q == LAST_COL) && (row_q == LAST_ROW);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      flip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      flip_q  <= flip_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    flip_d  = flip_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = DRAW;
          pos_x_d = pos_x_i;
          pos_y_d = pos_y_i;
          flip_d  = flip_h_i;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      DRAW: begin
        if (advance) begin
          // ROM is row-major, so the address simply counts up.
          addr_d = addr_q + 10'd1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (last_px) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    fb_we_o = (state_q == DRAW) && !skip;
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE);
  end

  assign rom_addr_o = addr_q;
  assign fb_x_o     = sx[9:0];
  assign fb_y_o     = sy[8:0];
  assign fb_data_o  = rom_color_i;

endmodule
